datapath_wall_multi: RTL and testbench

- Successor to the single-wall scroller datapath: moves NUM_WALLS walls leftward across the 160x120 playfield at a programmable rate.
- Regenerates each wall's hole Y from an internal LFSR on respawn.
- Counts score per wall passed and runs the post-collision freeze/restart sequence.
- Sits under the game control FSM, which asserts enable during its wall-update state; outputs feed the draw datapath and score display.

---
 rtl/wall_pkg.sv | 26 ++
 rtl/wall_tick_divider.sv | 43 ++++
 rtl/datapath_wall_multi.sv | 208 ++++++++++++++++++++
 tb/tb_datapath_wall_multi.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wall_pkg.sv
// Shared types and constants for the multi-wall scroller datapath:
// controller states, LFSR taps and default playfield geometry.
package wall_pkg;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      FREEZE = 1'b1
   } wall_state_e;

   // Galois toggle mask for x^8+x^6+x^5+x^4+1, right-shifting form
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam int DEF_SCREEN_W   = 160;
   localparam int DEF_HOLE_INIT  = 32;
   localparam int DEF_HOLE_MIN   = 8;
   localparam int DEF_HOLE_RANGE = 64;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return v[0] ? ({1'b0, v[7:1]} ^ LFSR_TAPS) : {1'b0, v[7:1]};
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
      return 8'(({v, v} << (n % 32'd8)) >> 32'd8);
   endfunction

endpackage

// File: rtl/wall_tick_divider.sv
// Movement tick generator: counts enabled clock cycles and pulses tick for
// one cycle every TICK_DIV of them.
module wall_tick_divider #(
   parameter int TICK_DIV = 833333
) (
   input  logic clk,
   input  logic resetn,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count and tick strobe; the count only moves while enabled
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (enable) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/datapath_wall_multi.sv
// Multi-wall scroller datapath: moves walls, respawns them with LFSR hole Y,
// scores passes and runs the freeze/restart sequence. Option: WALL_SPEEDUP_EN.
module datapath_wall_multi
   import wall_pkg::*;
#(
   parameter int         NUM_WALLS    = 2,
   parameter int         COORD_W      = 8,
   parameter int         SCREEN_W     = DEF_SCREEN_W,
   parameter int         WALL_SPACING = 80,
   parameter int         WALL_SPEED   = 1,
   parameter int         TICK_DIV     = 833333,
   parameter int         FREEZE_TICKS = 64,
   parameter int         HOLE_MIN     = DEF_HOLE_MIN,
   parameter int         HOLE_RANGE   = DEF_HOLE_RANGE,
   parameter int         HOLE_INIT    = DEF_HOLE_INIT,
   parameter int         SCORE_W      = 8,
   parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         enable,
   input  logic                         collision,
   output logic [NUM_WALLS*COORD_W-1:0] x_out,
   output logic [NUM_WALLS*COORD_W-1:0] y_out,
   output logic [SCORE_W-1:0]           score_out,
   output logic                         frozen,
   output logic                         step
);

   localparam int FZ_W  = $clog2(FREEZE_TICKS + 1);
   localparam int CNT_W = $clog2(NUM_WALLS + 1);
   localparam int SUM_W = SCORE_W + CNT_W;
   localparam logic [COORD_W-1:0] WRAP_DIST = COORD_W'(NUM_WALLS * WALL_SPACING);
   localparam logic [7:0]         HOLE_MASK = 8'(HOLE_RANGE - 1);
   localparam logic [SUM_W-1:0]   SCORE_MAX = SUM_W'((1 << SCORE_W) - 1);

   wall_state_e        state_q;
   wall_state_e        state_d;
   logic [FZ_W-1:0]    freeze_q;
   logic [FZ_W-1:0]    freeze_d;
   logic [7:0]         lfsr_q;
   logic [SCORE_W-1:0] score_q;
   logic [SCORE_W-1:0] score_d;
   logic               frozen_q;
   logic               step_q;
   logic               step_d;
   logic               tick_s;

   logic [COORD_W-1:0] x_q    [NUM_WALLS];
   logic [COORD_W-1:0] x_d    [NUM_WALLS];
   logic [COORD_W-1:0] y_q    [NUM_WALLS];
   logic [COORD_W-1:0] y_d    [NUM_WALLS];
   logic [COORD_W-1:0] x_mv_s [NUM_WALLS];
   logic [COORD_W-1:0] y_mv_s [NUM_WALLS];
   logic               respawn_s [NUM_WALLS];
   logic [CNT_W-1:0]   resp_cnt_s;
   logic [SUM_W-1:0]   score_sum_s;
   logic [COORD_W-1:0] speed_s;

   wall_tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .resetn (resetn),
      .enable (enable),
      .tick   (tick_s)
   );

   // Wrap arithmetic is modulo 2^COORD_W, identical to the truncated wide sum
   for (genvar g = 0; g < NUM_WALLS; g++) begin : g_wall
      assign respawn_s[g] = (x_q[g] <= speed_s);
      assign x_mv_s[g]    = respawn_s[g] ? (x_q[g] + WRAP_DIST - speed_s)
                                         : (x_q[g] - speed_s);
      assign y_mv_s[g]    = respawn_s[g]
                          ? (COORD_W'(HOLE_MIN) + COORD_W'(rotl8(lfsr_q, g) & HOLE_MASK))
                          : y_q[g];
      assign x_out[g*COORD_W +: COORD_W] = x_q[g];
      assign y_out[g*COORD_W +: COORD_W] = y_q[g];
   end

`ifdef WALL_SPEEDUP_EN
   logic [COORD_W-1:0] speed_q;
   logic [COORD_W-1:0] speed_d;
   logic               restart_s;

   assign restart_s = tick_s && (state_q == FREEZE) && (freeze_q == FZ_W'(FREEZE_TICKS));
   assign speed_s   = speed_q;

   // Speed bumps when a move carries the score across a multiple of 8
   always_comb begin
      speed_d = speed_q;
      if (restart_s) begin
         speed_d = COORD_W'(WALL_SPEED);
      end else if (step_d && ((score_d >> 2'd3) != (score_q >> 2'd3))
                   && (speed_q < COORD_W'(4))) begin
         speed_d = speed_q + COORD_W'(1);
      end else begin
         speed_d = speed_q;
      end
   end

   // Live speed register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         speed_q <= COORD_W'(WALL_SPEED);
      end else begin
         speed_q <= speed_d;
      end
   end
`else
   assign speed_s = COORD_W'(WALL_SPEED);
`endif

   // Number of walls respawning on this tick
   always_comb begin
      resp_cnt_s = '0;
      for (int i = 0; i < NUM_WALLS; i++) begin
         if (respawn_s[i]) begin
            resp_cnt_s = resp_cnt_s + CNT_W'(1);
         end else begin
            resp_cnt_s = resp_cnt_s;
         end
      end
   end

   assign score_sum_s = SUM_W'(score_q) + SUM_W'(resp_cnt_s);

   // Run/freeze controller and wall/score next state
   always_comb begin
      state_d  = state_q;
      freeze_d = freeze_q;
      score_d  = score_q;
      step_d   = 1'b0;
      for (int i = 0; i < NUM_WALLS; i++) begin
         x_d[i] = x_q[i];
         y_d[i] = y_q[i];
      end
      if (tick_s) begin
         case (state_q)
            RUN: begin
               if (collision) begin
                  state_d  = FREEZE;
                  freeze_d = FZ_W'(1);
               end else begin
                  for (int i = 0; i < NUM_WALLS; i++) begin
                     x_d[i] = x_mv_s[i];
                     y_d[i] = y_mv_s[i];
                  end
                  score_d = (score_sum_s > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                                      : score_sum_s[SCORE_W-1:0];
                  step_d  = 1'b1;
               end
            end
            FREEZE: begin
               if (freeze_q == FZ_W'(FREEZE_TICKS)) begin
                  state_d  = RUN;
                  freeze_d = '0;
                  score_d  = '0;
                  for (int i = 0; i < NUM_WALLS; i++) begin
                     x_d[i] = COORD_W'(SCREEN_W + i * WALL_SPACING);
                     y_d[i] = COORD_W'(HOLE_INIT);
                  end
               end else begin
                  freeze_d = freeze_q + FZ_W'(1);
               end
            end
            default: begin
               state_d  = RUN;
               freeze_d = '0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State, wall and output registers; the LFSR free-runs outside reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= RUN;
         freeze_q <= '0;
         lfsr_q   <= LFSR_SEED;
         score_q  <= '0;
         frozen_q <= 1'b0;
         step_q   <= 1'b0;
         for (int i = 0; i < NUM_WALLS; i++) begin
            x_q[i] <= COORD_W'(SCREEN_W + i * WALL_SPACING);
            y_q[i] <= COORD_W'(HOLE_INIT);
         end
      end else begin
         state_q  <= state_d;
         freeze_q <= freeze_d;
         lfsr_q   <= lfsr_step(lfsr_q);
         score_q  <= score_d;
         frozen_q <= (state_d == FREEZE);
         step_q   <= step_d;
         for (int i = 0; i < NUM_WALLS; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
         end
      end
   end

   assign score_out = score_q;
   assign frozen    = frozen_q;
   assign step      = step_q;

endmodule

// File: tb/tb_datapath_wall_multi.sv
// Randomised scoreboard bench for datapath_wall_multi against a behavioural
// model of the wall game rules.
module tb_datapath_wall_multi;

   localparam int NW  = 2;
   localparam int TD  = 4;
   localparam int FZ  = 64;
   localparam int SP  = 80;
   localparam int SWD = 160;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn = 1'b0;
   logic          enable = 1'b0;
   logic          collision = 1'b0;
   logic [15:0]   x_out, y_out;
   logic [7:0]    score_out;
   logic          frozen, step;

   logic          resetn2 = 1'b0;
   logic          en2 = 1'b1;
   logic          col2 = 1'b0;
   logic [15:0]   x2, y2;
   logic [1:0]    score2;
   logic          frozen2, step2;

   datapath_wall_multi #(.TICK_DIV(TD)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .collision(collision),
      .x_out(x_out), .y_out(y_out), .score_out(score_out),
      .frozen(frozen), .step(step)
   );

   datapath_wall_multi #(.TICK_DIV(2), .SCORE_W(2)) dut2 (
      .clk(clk), .resetn(resetn2), .enable(en2), .collision(col2),
      .x_out(x2), .y_out(y2), .score_out(score2),
      .frozen(frozen2), .step(step2)
   );

   int checks = 0;
   int passes = 0;
   logic [63:0] exp_q [$];
   bit d2_done = 1'b0;

   int m_x [NW];
   int m_y [NW];
   int m_sc, m_fc, m_cnt, m_lfsr, m_spd;
   bit m_fz;
   bit m_rst = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   function automatic int lfsr_next(input int v);
      return (v & 1) ? ((v >> 1) ^ 'hB8) : (v >> 1);
   endfunction

   function automatic int rotl(input int v, input int n);
      return ((v << n) | (v >> (8 - n))) & 255;
   endfunction

   function automatic logic [63:0] snap(input int x0, input int x1, input int y0,
                                        input int y1, input int sc, input bit fr, input bit st);
      return {22'd0, 8'(x1), 8'(x0), 8'(y1), 8'(y0), 8'(sc), fr, st};
   endfunction

   function automatic logic [63:0] dut_snap();
      return {22'd0, x_out, y_out, score_out, frozen, step};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NW; i++) begin
         m_x[i] = SWD + i * SP;
         m_y[i] = 32;
      end
      m_sc = 0; m_fc = 0; m_cnt = 0; m_lfsr = 'hA5; m_spd = 1; m_fz = 1'b0;
   endtask

   // One clock edge of the game rules, with the inputs seen at that edge
   task automatic model_clock(input bit rn, input bit en, input bit col);
      int lf_old;
      int n;
      int old_sc;
      bit tick;
      if (!rn) begin
         model_reset();
         m_rst = 1'b1;
         return;
      end
      m_rst  = 1'b0;
      lf_old = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      tick   = 1'b0;
      if (en) begin
         if (m_cnt == TD - 1) begin m_cnt = 0; tick = 1'b1; end
         else m_cnt++;
      end
      if (!tick) return;
      if (!m_fz) begin
         if (col) begin
            m_fz = 1'b1;
            m_fc = 1;
            exp_q.push_back(snap(m_x[0], m_x[1], m_y[0], m_y[1], m_sc, 1'b1, 1'b0));
         end else begin
            n = 0;
            for (int i = 0; i < NW; i++) begin
               if (m_x[i] > m_spd) m_x[i] = m_x[i] - m_spd;
               else begin
                  m_x[i] = (m_x[i] + NW * SP - m_spd) % 256;
                  m_y[i] = 8 + (rotl(lf_old, i) % 64);
                  n++;
               end
            end
            old_sc = m_sc;
            m_sc = (m_sc + n > 255) ? 255 : m_sc + n;
`ifdef WALL_SPEEDUP_EN
            if ((m_sc / 8 != old_sc / 8) && m_spd < 4) m_spd++;
`endif
            exp_q.push_back(snap(m_x[0], m_x[1], m_y[0], m_y[1], m_sc, 1'b0, 1'b1));
         end
      end else begin
         if (m_fc == FZ) begin
            n = m_lfsr;
            model_reset();
            m_lfsr = n;
            exp_q.push_back(snap(m_x[0], m_x[1], m_y[0], m_y[1], m_sc, 1'b0, 1'b0));
         end else begin
            m_fc++;
         end
      end
   endtask

   task automatic drive(input bit rn, input bit en, input bit col);
      resetn = rn; enable = en; collision = col;
      @(posedge clk);
      model_clock(rn, en, col);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_x"}, x_out, {8'd240, 8'd160});
      chk({tag, "_y"}, y_out, {8'd32, 8'd32});
      chk({tag, "_score"}, score_out, 8'd0);
      chk({tag, "_frozen"}, frozen, 1'b0);
      chk({tag, "_step"}, step, 1'b0);
   endtask

   // Monitor: every step pulse or frozen transition consumes one expectation
   initial begin
      bit prev_fr;
      logic [63:0] e;
      prev_fr = 1'b0;
      forever begin
         @(negedge clk);
         if (!m_rst && (step === 1'b1 || frozen !== prev_fr)) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL sb_unexpected_event: actual=%0h required=none", dut_snap());
            end else begin
               e = exp_q.pop_front();
               chk("sb_event", dut_snap(), e);
            end
         end
         prev_fr = frozen;
      end
   end

   // Narrow-score instance: five respawns must saturate at 3
   initial begin
      repeat (3) @(posedge clk);
      #2 resetn2 = 1'b1;
      repeat (560) @(posedge clk);
      #2 chk("dut2_score_two", score2, 2'd2);
      repeat (540) @(posedge clk);
      #2 chk("dut2_score_sat", score2, 2'd3);
      d2_done = 1'b1;
   end

   initial begin
      int k;
      bit seen;
      model_reset();
      repeat (3) drive(1'b0, 1'b1, 1'b0);
      #4 check_reset_values("reset");

      seen = 1'b0;
      k = 0;
      while (!seen && k < 20) begin
         drive(1'b1, 1'b1, 1'b0);
         k++;
         #4 seen = (step === 1'b1);
      end
      chk("first_step_latency", k, 4);
      chk("first_step_x", x_out, {8'd239, 8'd159});

      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      repeat (10) drive(1'b1, 1'b0, 1'b0);
      seen = 1'b0;
      k = 0;
      while (!seen && k < 20) begin
         drive(1'b1, 1'b1, 1'b0);
         k++;
         #4 seen = (step === 1'b1);
      end
      chk("hold_step_latency", k, 2);

      repeat (4400) drive(1'b1, ($urandom_range(0, 3) != 0), 1'b0);

      repeat (TD) drive(1'b1, 1'b1, 1'b1);
      #4 chk("collision_frozen", frozen, 1'b1);
      repeat (FZ * TD) drive(1'b1, 1'b1, ($urandom_range(0, 7) == 0));
      #4 check_reset_values("restart");

      repeat (2000) drive(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));

      repeat (TD) drive(1'b1, 1'b1, 1'b1);
      repeat (40) drive(1'b1, 1'b1, 1'b0);
      #4 chk("pre_reset_frozen", frozen, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      #4 check_reset_values("midfreeze_reset");

      repeat (1000) drive(1'b1, ($urandom_range(0, 3) != 0), 1'b0);
      repeat (1000) drive(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));

      @(negedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 0);
      chk("dut2_done", d2_done, 1'b1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
